fetch_queue: RTL and testbench

Instruction prefetch queue between the instruction fetch unit and decode in the pipelined MIPS core. It buffers up to DEPTH fetched {instruction, PC+4} pairs so fetch keeps running while decode stalls. A branch or jump redirect flushes all buffered entries in one cycle. It is a registered FIFO with valid/ready handshakes on both sides.

---
 rtl/fetch_queue_pkg.sv | 32 +++
 rtl/fetch_queue_if.sv | 29 ++
 rtl/fetch_queue_mem.sv | 28 ++
 rtl/fetch_queue.sv | 74 +++++++
 tb/tb_fetch_queue.sv | 143 ++++++++++++++
 5 files changed

// File: rtl/fetch_queue_pkg.sv
// Shared definitions for the instruction prefetch queue and its neighbours.
// Holds the fetch-side constants, the stored entry layout and the occupancy
// classification derived from the entry count.
package fetch_queue_pkg;

  localparam logic [31:0] TEXT_BASE = 32'h0000_3000;
  localparam logic [31:0] INSTR_NOP = 32'h0000_0000;
  localparam int unsigned FQ_DEPTH  = 4;

  // One buffered fetch result: instruction in the upper half, PC+4 in the lower.
  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc4;
  } fq_entry_t;

  typedef enum logic [1:0] {
    OccEmpty,
    OccPartial,
    OccFull
  } occ_e;

  function automatic occ_e occ_of(input logic [31:0] count, input logic [31:0] depth);
    if (count == 32'd0) begin
      return OccEmpty;
    end else if (count == depth) begin
      return OccFull;
    end else begin
      return OccPartial;
    end
  endfunction

endpackage

// File: rtl/fetch_queue_if.sv
// Handshake bundle between fetch, the prefetch queue and decode.
//   master : fetch/decode side - drives in_valid/in_instr/in_PC4/in_flush/out_ready
//   slave  : queue side        - drives in_ready/out_valid/out_instr/out_PC4/out_count
interface fetch_queue_if #(
  parameter int unsigned CW = 3
) ();

  logic          in_valid;
  logic [31:0]   in_instr;
  logic [31:0]   in_PC4;
  logic          in_ready;
  logic          in_flush;
  logic          out_valid;
  logic [31:0]   out_instr;
  logic [31:0]   out_PC4;
  logic          out_ready;
  logic [CW-1:0] out_count;

  modport master (
    output in_valid, in_instr, in_PC4, in_flush, out_ready,
    input  in_ready, out_valid, out_instr, out_PC4, out_count
  );

  modport slave (
    input  in_valid, in_instr, in_PC4, in_flush, out_ready,
    output in_ready, out_valid, out_instr, out_PC4, out_count
  );

endinterface

// File: rtl/fetch_queue_mem.sv
// DEPTH x 64-bit entry storage for the prefetch queue.
// Ports: clk, we/waddr/wdata (synchronous write), raddr/rdata (asynchronous read).
// Holds no control state; contents are not reset.
module fetch_queue_mem
  import fetch_queue_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned AW    = 2
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  fq_entry_t     wdata,
  input  logic [AW-1:0] raddr,
  output fq_entry_t     rdata
);

  fq_entry_t mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/fetch_queue.sv
// Instruction prefetch queue between fetch and decode: a registered FIFO of
// {instr, PC+4} pairs with valid/ready on both sides and a one-cycle flush.
// Ports: clk, reset (synchronous, active-low), bus (fetch_queue_if.slave).
// Outputs depend only on registered state, so they move only at clk edges.
module fetch_queue
  import fetch_queue_pkg::*;
#(
  parameter int unsigned DEPTH = FQ_DEPTH,
  parameter int unsigned CW    = 3
) (
  input logic           clk,
  input logic           reset,
  fetch_queue_if.slave  bus
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [AW-1:0] wp_q, rp_q;
  logic [CW-1:0] count_q;
  occ_e          occ;
  logic          push, pop;
  fq_entry_t     wdata, rdata;

  assign occ = occ_of(32'(count_q), 32'(DEPTH));

  // Ready looks only at the registered count: a pop while full does not free a slot
  // for a push in the same cycle.
  assign bus.in_ready  = (occ != OccFull);
  assign bus.out_valid = (occ != OccEmpty);
  assign bus.out_count = count_q;

  assign push = bus.in_valid && bus.in_ready;
  assign pop  = bus.out_valid && bus.out_ready;

  assign wdata = '{instr: bus.in_instr, pc4: bus.in_PC4};

  // Empty queue presents a NOP rather than whatever stale word sits at rp.
  assign bus.out_instr = bus.out_valid ? rdata.instr : INSTR_NOP;
  assign bus.out_PC4   = bus.out_valid ? rdata.pc4 : 32'h0;

  fetch_queue_mem #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_mem (
    .clk   (clk),
    .we    (push && reset && !bus.in_flush),
    .waddr (wp_q),
    .wdata (wdata),
    .raddr (rp_q),
    .rdata (rdata)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      wp_q    <= '0;
      rp_q    <= '0;
      count_q <= '0;
    end else if (bus.in_flush) begin
      wp_q    <= '0;
      rp_q    <= '0;
      count_q <= '0;
    end else begin
      // Pointers wrap through natural binary overflow.
      if (push) wp_q <= wp_q + AW'(1);
      if (pop)  rp_q <= rp_q + AW'(1);
      unique case ({push, pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_queue.sv
module tb_fetch_queue;
  import fetch_queue_pkg::*;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned CW    = 3;

  logic clk;
  logic reset;

  fetch_queue_if #(.CW(CW)) bus ();

  fetch_queue #(
    .DEPTH (DEPTH),
    .CW    (CW)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned passes;
  int unsigned total;
  fq_entry_t   sb[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passes++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  // One clock cycle: drive inputs, check outputs against the model, update the
  // model as the queue should at the coming edge, then advance past the edge.
  task automatic cycle(input logic v, input logic [31:0] ins, input logic [31:0] pc,
                       input logic rdy, input logic fl, input logic rst_n);
    bit   exp_push, exp_pop;
    int   n;
    bus.in_valid  = v;
    bus.in_instr  = ins;
    bus.in_PC4    = pc;
    bus.out_ready = rdy;
    bus.in_flush  = fl;
    reset         = rst_n;
    #1;
    n = sb.size();
    chk("in_ready", 64'(bus.in_ready), 64'(n != DEPTH));
    chk("out_valid", 64'(bus.out_valid), 64'(n != 0));
    chk("out_count", 64'(bus.out_count), 64'(n));
    if (n != 0) begin
      chk("out_instr", 64'(bus.out_instr), 64'(sb[0].instr));
      chk("out_PC4", 64'(bus.out_PC4), 64'(sb[0].pc4));
    end else begin
      chk("out_instr_nop", 64'(bus.out_instr), 64'(INSTR_NOP));
      chk("out_PC4_zero", 64'(bus.out_PC4), 64'h0);
    end
    if (!rst_n || fl) begin
      sb.delete();
    end else begin
      exp_push = v && (n != DEPTH);
      exp_pop  = rdy && (n != 0);
      if (exp_pop)  void'(sb.pop_front());
      if (exp_push) sb.push_back('{instr: ins, pc4: pc});
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    cycle(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic push1(input logic [31:0] ins, input logic [31:0] pc);
    cycle(1'b1, ins, pc, 1'b0, 1'b0, 1'b1);
  endtask

  initial begin
    passes = 0;
    total  = 0;
    bus.in_valid  = 1'b0;
    bus.in_instr  = '0;
    bus.in_PC4    = '0;
    bus.out_ready = 1'b0;
    bus.in_flush  = 1'b0;
    reset         = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // Reset then idle.
    idle();
    chk("rst_wp", 64'(dut.wp_q), 64'h0);
    chk("rst_rp", 64'(dut.rp_q), 64'h0);

    // Fill, ignored 5th push, drain in order.
    push1(32'h3C01_0001, 32'h3004);
    push1(32'h3421_0002, 32'h3008);
    push1(32'h0000_0000, 32'h300C);
    push1(32'h1000_FFFF, 32'h3010);
    push1(32'hDEAD_BEEF, 32'h3014);
    chk("full_ready_low", 64'(bus.in_ready), 64'h0);
    chk("full_count", 64'(bus.out_count), 64'd4);
    repeat (4) cycle(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b1);
    idle();

    // Concurrent push/pop across pointer wrap at count 2.
    push1(32'h2000_0001, 32'h3018);
    push1(32'h2000_0002, 32'h301C);
    for (int i = 0; i < 6; i++) begin
      cycle(1'b1, 32'h2100_0000 + 32'(i), 32'h3020 + 32'(4 * i), 1'b1, 1'b0, 1'b1);
    end
    chk("concurrent_count", 64'(bus.out_count), 64'd2);

    // Full with pop: push rejected, count drops to 3.
    push1(32'h2200_0001, 32'h3100);
    push1(32'h2200_0002, 32'h3104);
    cycle(1'b1, 32'hBAD0_0001, 32'h3108, 1'b1, 1'b0, 1'b1);
    chk("full_pop_count", 64'(bus.out_count), 64'd3);

    // Flush beats a simultaneous push and pop.
    cycle(1'b1, 32'h0800_0C00, 32'h310C, 1'b1, 1'b1, 1'b1);
    chk("flush_count", 64'(bus.out_count), 64'd0);
    chk("flush_ready", 64'(bus.in_ready), 64'h1);
    idle();
    chk("flush_word_absent", 64'(bus.out_instr == 32'h0800_0C00), 64'h0);

    // Reset mid-operation.
    push1(32'h2300_0001, 32'h3200);
    push1(32'h2300_0002, 32'h3204);
    cycle(1'b1, 32'h2300_0003, 32'h3208, 1'b0, 1'b0, 1'b0);
    chk("midrst_count", 64'(bus.out_count), 64'd0);
    chk("midrst_wp", 64'(dut.wp_q), 64'h0);
    chk("midrst_rp", 64'(dut.rp_q), 64'h0);
    push1(32'h2400_0001, TEXT_BASE + 32'h4);
    chk("post_rst_instr", 64'(bus.out_instr), 64'h2400_0001);
    cycle(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b1);
    idle();

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule
